// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue buffer: op codes, opcodes, entry layout.
// ALU_ISSUE_ILLEGAL_EN adds a per-entry illegal flag.
package alu_issue_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd;
    logic        rd_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        illegal;
`endif
  } entry_t;

  function automatic alu_op_e f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decoder: instruction plus operands to issue entry.
// ALU_ISSUE_ILLEGAL_EN also reports unsupported encodings.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output entry_t      ent
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;
  logic        w_bad;
  logic        w_unused_rs1f;

  assign w_opc   = instr[6:0];
  assign w_f3    = instr[14:12];
  assign w_f7    = instr[31:25];
  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_u = {instr[31:12], 12'b0};
  assign w_shamt = {27'b0, instr[24:20]};

  // Register numbers arrive already resolved as operand data.
  assign w_unused_rs1f = ^instr[19:15];

  always_comb begin
    ent       = '0;
    w_bad     = 1'b0;
    ent.rd    = instr[11:7];
    unique case (1'b1)
      (w_opc == OPC_OP): begin
        w_bad = !((w_f7 == F7_ZERO) ||
                  ((w_f7 == F7_ALT) &&
                   ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
        ent.alu_op = f3_op(w_f3, w_f7[5]);
        ent.src_a  = rs1_data;
        ent.src_b  = rs2_data;
        ent.rd_we  = 1'b1;
      end
      (w_opc == OPC_IMM): begin
        ent.alu_op = f3_op(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        ent.src_a  = rs1_data;
        ent.src_b  = w_imm_i;
        ent.rd_we  = 1'b1;
        if (w_f3 == 3'b001) begin
          w_bad     = (w_f7 != F7_ZERO);
          ent.src_b = w_shamt;
        end
        if (w_f3 == 3'b101) begin
          w_bad     = !((w_f7 == F7_ZERO) || (w_f7 == F7_ALT));
          ent.src_b = w_shamt;
        end
      end
      (w_opc == OPC_LUI): begin
        ent.alu_op = ALU_PASSB;
        ent.src_b  = w_imm_u;
        ent.rd_we  = 1'b1;
      end
      (w_opc == OPC_AUIPC): begin
        ent.alu_op = ALU_ADD;
        ent.src_a  = pc;
        ent.src_b  = w_imm_u;
        ent.rd_we  = 1'b1;
      end
      (w_opc == OPC_LOAD): begin
        ent.alu_op = ALU_ADD;
        ent.src_a  = rs1_data;
        ent.src_b  = w_imm_i;
        ent.rd_we  = 1'b1;
      end
      (w_opc == OPC_STORE): begin
        ent.alu_op = ALU_ADD;
        ent.src_a  = rs1_data;
        ent.src_b  = w_imm_s;
        ent.rd_we  = 1'b0;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      ent.alu_op = ALU_ADD;
      ent.src_a  = '0;
      ent.src_b  = '0;
      ent.rd_we  = 1'b0;
    end
    if (ent.rd == 5'd0) ent.rd_we = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    ent.illegal = w_bad;
`endif
  end

endmodule

// File: rtl/alu_issue.sv
// Two-entry issue buffer between register read and the ALU stage.
// ALU_ISSUE_ILLEGAL_EN adds the illegal output.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [4:0]  rd,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic        rd_we,
  output logic        illegal
`else
  output logic        rd_we
`endif
);

  state_e r_state;
  state_e w_nstate;
  logic   r_in_ready;
  entry_t r_ent0;
  entry_t r_ent1;
  entry_t w_ent0_n;
  entry_t w_ent1_n;
  entry_t w_dec;
  logic   w_push;
  logic   w_pop;

  alu_issue_dec u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .ent      (w_dec)
  );

  assign out_valid = (r_state != S_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_push    = in_valid && r_in_ready && !flush;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
      r_ent0     <= '0;
      r_ent1     <= '0;
    end else begin
      r_state    <= w_nstate;
      r_in_ready <= (w_nstate != S_TWO);
      r_ent0     <= w_ent0_n;
      r_ent1     <= w_ent1_n;
    end
  end

  // r_ent0 is always the head; r_ent1 only holds data in S_TWO.
  always_comb begin
    w_nstate = r_state;
    w_ent0_n = r_ent0;
    w_ent1_n = r_ent1;
    if (flush) begin
      w_nstate = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_nstate = S_ONE;
            w_ent0_n = w_dec;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_ent0_n = w_dec;
          end else if (w_push) begin
            w_nstate = S_TWO;
            w_ent1_n = w_dec;
          end else if (w_pop) begin
            w_nstate = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_nstate = S_ONE;
            w_ent0_n = r_ent1;
          end
        end
        default: w_nstate = S_EMPTY;
      endcase
    end
  end

  assign alu_op = r_ent0.alu_op;
  assign SrcA   = r_ent0.src_a;
  assign SrcB   = r_ent0.src_b;
  assign rd     = r_ent0.rd;
  assign rd_we  = r_ent0.rd_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal = r_ent0.illegal;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode table, backpressure, flush, reset.
// Checks the illegal port when ALU_ISSUE_ILLEGAL_EN is defined.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  rd;
  logic        rd_we;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        illegal;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ADD_X3 = 32'h002081B3;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [4:0]  erd;
    logic        ewe;
    logic        eill;
  } vec_t;

  vec_t vt[11];

  alu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .rd        (rd),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .rd_we     (rd_we),
    .illegal   (illegal)
`else
    .rd_we     (rd_we)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] a);
    in_valid = 1'b1;
    instr    = ins;
    pc       = 32'h0000_0400;
    rs1_data = a;
    rs2_data = 32'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{32'h002081B3, 32'h100, 32'd5, 32'd7,
               5'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0};
    vt[1]  = '{32'h40208333, 32'h104, 32'd10, 32'd3,
               5'd1, 32'd10, 32'd3, 5'd6, 1'b1, 1'b0};
    vt[2]  = '{32'h4030D213, 32'h108, 32'h80000000, 32'd0,
               5'd7, 32'h80000000, 32'd3, 5'd4, 1'b1, 1'b0};
    vt[3]  = '{32'h123452B7, 32'h10C, 32'hAAAA, 32'd1,
               5'd10, 32'd0, 32'h12345000, 5'd5, 1'b1, 1'b0};
    vt[4]  = '{32'h00001397, 32'h200, 32'd1, 32'd1,
               5'd0, 32'h200, 32'h1000, 5'd7, 1'b1, 1'b0};
    vt[5]  = '{32'hFFC0A403, 32'h204, 32'h1000, 32'd1,
               5'd0, 32'h1000, 32'hFFFFFFFC, 5'd8, 1'b1, 1'b0};
    vt[6]  = '{32'h0020A423, 32'h208, 32'h2000, 32'h55,
               5'd0, 32'h2000, 32'd8, 5'd8, 1'b0, 1'b0};
    vt[7]  = '{32'hFFF0F493, 32'h20C, 32'h1234, 32'd0,
               5'd9, 32'h1234, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0};
    vt[8]  = '{32'h00108013, 32'h210, 32'd4, 32'd0,
               5'd0, 32'd4, 32'd1, 5'd0, 1'b0, 1'b0};
    vt[9]  = '{32'h300010F3, 32'h214, 32'd9, 32'd9,
               5'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1};
    vt[10] = '{32'h40209133, 32'h218, 32'd1, 32'd2,
               5'd0, 32'd0, 32'd0, 5'd2, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.alu_op", 32'(alu_op), 0);
    chk("rst.srca", SrcA, 0);
    chk("rst.srcb", SrcB, 0);
    chk("rst.rd", 32'(rd), 0);
    chk("rst.rd_we", 32'(rd_we), 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("rst.illegal", 32'(illegal), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel.in_ready_low", 32'(in_ready), 0);
    tick();
    chk("rel.in_ready", 32'(in_ready), 1);
    chk("rel.out_valid", 32'(out_valid), 0);

    out_ready = 1'b1;
    foreach (vt[i]) begin
      in_valid = 1'b1;
      instr    = vt[i].ins;
      pc       = vt[i].pcv;
      rs1_data = vt[i].a;
      rs2_data = vt[i].b;
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d.valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d.op", i), 32'(alu_op), 32'(vt[i].op));
      chk($sformatf("v%0d.srca", i), SrcA, vt[i].ea);
      chk($sformatf("v%0d.srcb", i), SrcB, vt[i].eb);
      chk($sformatf("v%0d.rd", i), 32'(rd), 32'(vt[i].erd));
      chk($sformatf("v%0d.we", i), 32'(rd_we), 32'(vt[i].ewe));
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk($sformatf("v%0d.ill", i), 32'(illegal), 32'(vt[i].eill));
`endif
    end
    tick();
    chk("drain.out_valid", 32'(out_valid), 0);

    out_ready = 1'b0;
    put(ADD_X3, 32'h11);
    tick();
    chk("bp.a.in_ready", 32'(in_ready), 1);
    chk("bp.a.head", SrcA, 32'h11);
    put(ADD_X3, 32'h22);
    tick();
    chk("bp.full.in_ready", 32'(in_ready), 0);
    chk("bp.b.head", SrcA, 32'h11);
    put(ADD_X3, 32'h33);
    tick();
    chk("bp.c.in_ready", 32'(in_ready), 0);
    chk("bp.hold1", SrcA, 32'h11);
    tick();
    chk("bp.hold2", SrcA, 32'h11);
    chk("bp.hold2.rd", 32'(rd), 3);
    out_ready = 1'b1;
    tick();
    chk("bp.rel.b", SrcA, 32'h22);
    chk("bp.rel.in_ready", 32'(in_ready), 1);
    tick();
    chk("bp.rel.c", SrcA, 32'h33);
    chk("bp.rel.c.valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("bp.empty", 32'(out_valid), 0);

    out_ready = 1'b0;
    put(ADD_X3, 32'd100);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      put(ADD_X3, 32'd200 + 32'(i));
      tick();
      chk($sformatf("st%0d.head", i), SrcA, 32'd200 + 32'(i));
      chk($sformatf("st%0d.in_ready", i), 32'(in_ready), 1);
      chk($sformatf("st%0d.valid", i), 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("st.empty", 32'(out_valid), 0);

    out_ready = 1'b0;
    put(ADD_X3, 32'd1);
    tick();
    put(ADD_X3, 32'd2);
    tick();
    chk("fl.full", 32'(in_ready), 0);
    put(ADD_X3, 32'hDEAD);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.out_valid", 32'(out_valid), 0);
    chk("fl.in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    chk("fl.never", 32'(out_valid), 0);
    out_ready = 1'b0;
    put(ADD_X3, 32'd5);
    tick();
    put(ADD_X3, 32'hBEEF);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1.out_valid", 32'(out_valid), 0);
    tick();
    chk("fl1.never", 32'(out_valid), 0);

    put(ADD_X3, 32'd7);
    tick();
    put(ADD_X3, 32'd8);
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr.out_valid", 32'(out_valid), 0);
    chk("mr.in_ready", 32'(in_ready), 0);
    chk("mr.alu_op", 32'(alu_op), 0);
    chk("mr.srca", SrcA, 0);
    chk("mr.srcb", SrcB, 0);
    chk("mr.rd", 32'(rd), 0);
    chk("mr.rd_we", 32'(rd_we), 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mr.rel.in_ready", 32'(in_ready), 1);
    chk("mr.rel.out_valid", 32'(out_valid), 0);
    tick();
    chk("mr.rel.stay_empty", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
